// File: rtl/morse_keyer_pkg.sv
// Shared types and constants for the Morse keyer: state encoding, symbol codes,
// default unit counts and the ROM entry layout.
package morse_keyer_pkg;

  localparam int unsigned SYM_W  = 6;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned PAT_W  = 5;
  localparam int unsigned TONE_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    MARK  = 3'd2,
    EGAP  = 3'd3,
    LGAP  = 3'd4,
    WGAP  = 3'd5
  } state_t;

  localparam logic [SYM_W-1:0] SYM_SPACE     = SYM_W'(36);
  localparam logic [SYM_W-1:0] SYM_MAX_VALID = SYM_W'(36);

  localparam int unsigned DASH_UNITS_DEF = 3;
  localparam int unsigned LGAP_UNITS_DEF = 3;
  localparam int unsigned WGAP_UNITS_DEF = 4;
  localparam int unsigned TONE_DIV_DEF   = 50000;

  // pat is left-justified: element i of a len-element code sits at bit PAT_W-1-i
  typedef struct packed {
    logic             valid;
    logic             is_space;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } rom_entry_t;

endpackage

// File: rtl/morse_rom.sv
// Symbol code to dot/dash pattern lookup (A-Z, 0-9, space); 1 = dash, MSB first.
module morse_rom
  import morse_keyer_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output rom_entry_t       entry_c
);

  always_comb begin
    entry_c          = '0;
    entry_c.valid    = (sym <= SYM_MAX_VALID);
    entry_c.is_space = (sym == SYM_SPACE);
    case (sym)
      6'd0:  {entry_c.len, entry_c.pat} = {3'd2, 5'b01000}; // A
      6'd1:  {entry_c.len, entry_c.pat} = {3'd4, 5'b10000}; // B
      6'd2:  {entry_c.len, entry_c.pat} = {3'd4, 5'b10100}; // C
      6'd3:  {entry_c.len, entry_c.pat} = {3'd3, 5'b10000}; // D
      6'd4:  {entry_c.len, entry_c.pat} = {3'd1, 5'b00000}; // E
      6'd5:  {entry_c.len, entry_c.pat} = {3'd4, 5'b00100}; // F
      6'd6:  {entry_c.len, entry_c.pat} = {3'd3, 5'b11000}; // G
      6'd7:  {entry_c.len, entry_c.pat} = {3'd4, 5'b00000}; // H
      6'd8:  {entry_c.len, entry_c.pat} = {3'd2, 5'b00000}; // I
      6'd9:  {entry_c.len, entry_c.pat} = {3'd4, 5'b01110}; // J
      6'd10: {entry_c.len, entry_c.pat} = {3'd3, 5'b10100}; // K
      6'd11: {entry_c.len, entry_c.pat} = {3'd4, 5'b01000}; // L
      6'd12: {entry_c.len, entry_c.pat} = {3'd2, 5'b11000}; // M
      6'd13: {entry_c.len, entry_c.pat} = {3'd2, 5'b10000}; // N
      6'd14: {entry_c.len, entry_c.pat} = {3'd3, 5'b11100}; // O
      6'd15: {entry_c.len, entry_c.pat} = {3'd4, 5'b01100}; // P
      6'd16: {entry_c.len, entry_c.pat} = {3'd4, 5'b11010}; // Q
      6'd17: {entry_c.len, entry_c.pat} = {3'd3, 5'b01000}; // R
      6'd18: {entry_c.len, entry_c.pat} = {3'd3, 5'b00000}; // S
      6'd19: {entry_c.len, entry_c.pat} = {3'd1, 5'b10000}; // T
      6'd20: {entry_c.len, entry_c.pat} = {3'd3, 5'b00100}; // U
      6'd21: {entry_c.len, entry_c.pat} = {3'd4, 5'b00010}; // V
      6'd22: {entry_c.len, entry_c.pat} = {3'd3, 5'b01100}; // W
      6'd23: {entry_c.len, entry_c.pat} = {3'd4, 5'b10010}; // X
      6'd24: {entry_c.len, entry_c.pat} = {3'd4, 5'b10110}; // Y
      6'd25: {entry_c.len, entry_c.pat} = {3'd4, 5'b11000}; // Z
      6'd26: {entry_c.len, entry_c.pat} = {3'd5, 5'b11111}; // 0
      6'd27: {entry_c.len, entry_c.pat} = {3'd5, 5'b01111}; // 1
      6'd28: {entry_c.len, entry_c.pat} = {3'd5, 5'b00111}; // 2
      6'd29: {entry_c.len, entry_c.pat} = {3'd5, 5'b00011}; // 3
      6'd30: {entry_c.len, entry_c.pat} = {3'd5, 5'b00001}; // 4
      6'd31: {entry_c.len, entry_c.pat} = {3'd5, 5'b00000}; // 5
      6'd32: {entry_c.len, entry_c.pat} = {3'd5, 5'b10000}; // 6
      6'd33: {entry_c.len, entry_c.pat} = {3'd5, 5'b11000}; // 7
      6'd34: {entry_c.len, entry_c.pat} = {3'd5, 5'b11100}; // 8
      6'd35: {entry_c.len, entry_c.pat} = {3'd5, 5'b11110}; // 9
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keying engine: one symbol per valid/ready handshake, timed in CLK_2 units.
// Optional tone output enabled by defining MORSE_KEYER_BUZZER_EN.
module morse_keyer
  import morse_keyer_pkg::*;
#(
  parameter int unsigned DASH_UNITS = DASH_UNITS_DEF,
  parameter int unsigned LGAP_UNITS = LGAP_UNITS_DEF,
  parameter int unsigned WGAP_UNITS = WGAP_UNITS_DEF,
  parameter int unsigned TONE_DIV   = TONE_DIV_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_2,
  input  logic [SYM_W-1:0] SYM,
  input  logic             VALID,
  output logic             READY,
  output logic             MORSE_OUT,
  output logic             BUSY,
  output logic             ERR,
  output logic             BUZZER
);

  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] LGAP_CNT = CNT_W'(LGAP_UNITS);
  localparam logic [CNT_W-1:0] WGAP_CNT = CNT_W'(WGAP_UNITS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  if (DASH_UNITS == 0 || DASH_UNITS > 7 || LGAP_UNITS == 0 || LGAP_UNITS > 7 ||
      WGAP_UNITS == 0 || WGAP_UNITS > 7 || TONE_DIV == 0 || TONE_DIV > 65536) begin : g_bad_param
    $error("morse_keyer: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             space_q, space_d;
  logic             err_d;
  logic             c2_q;
  logic             tick_c;
  logic             handshake_c;
  rom_entry_t       rom_c;

  morse_rom u_rom (
    .sym     (SYM),
    .entry_c (rom_c)
  );

  assign tick_c      = CLK_2 & ~c2_q;
  assign handshake_c = VALID & READY;

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pat_d   = pat_q;
    space_d = space_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake_c) begin
          if (!rom_c.valid) begin
            err_d = 1'b1;
          end else begin
            state_d = ALIGN;
            len_d   = rom_c.len;
            pat_d   = rom_c.pat;
            space_d = rom_c.is_space;
          end
        end
      end
      ALIGN: begin
        if (tick_c) begin
          if (space_q) begin
            state_d = WGAP;
            cnt_d   = WGAP_CNT;
          end else begin
            state_d = MARK;
            cnt_d   = pat_q[PAT_W-1] ? DASH_CNT : ONE_CNT;
          end
        end
      end
      MARK: begin
        if (tick_c) begin
          if (cnt_q == ONE_CNT) begin
            if (len_q > LEN_W'(1)) begin
              state_d = EGAP;
              cnt_d   = ONE_CNT;
            end else begin
              state_d = LGAP;
              cnt_d   = LGAP_CNT;
            end
          end else begin
            cnt_d = cnt_q - ONE_CNT;
          end
        end
      end
      EGAP: begin
        if (tick_c) begin
          if (cnt_q == ONE_CNT) begin
            // pat_q[PAT_W-2] becomes the head element once shifted
            state_d = MARK;
            pat_d   = {pat_q[PAT_W-2:0], 1'b0};
            len_d   = len_q - LEN_W'(1);
            cnt_d   = pat_q[PAT_W-2] ? DASH_CNT : ONE_CNT;
          end else begin
            cnt_d = cnt_q - ONE_CNT;
          end
        end
      end
      LGAP, WGAP: begin
        if (tick_c) begin
          if (cnt_q == ONE_CNT) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - ONE_CNT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      pat_q     <= '0;
      space_q   <= 1'b0;
      c2_q      <= 1'b0;
      READY     <= 1'b0;
      MORSE_OUT <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      space_q   <= space_d;
      c2_q      <= CLK_2;
      READY     <= (state_d == IDLE);
      MORSE_OUT <= (state_d == MARK);
      BUSY      <= (state_d != IDLE);
      ERR       <= err_d;
    end
  end

`ifdef MORSE_KEYER_BUZZER_EN
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic              tone_q;

  // tone runs only while keyed and restarts from a known phase on each mark
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (!MORSE_OUT) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + TONE_W'(1);
    end
  end

  assign BUZZER = tone_q;
`else
  assign BUZZER = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: table of letters with expected mark/gap
// run lengths plus directed sequences for back-to-back, invalid code and reset.
module tb_morse_keyer;

  localparam int P     = 20;    // CLK cycles per CLK_2 unit
  localparam int BOUND = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_2 = 1'b0;
  logic [5:0] sym = 6'd0;
  logic       valid = 1'b0;
  logic       ready, morse_out, busy, err, buzzer;

  int n_chk  = 0;
  int n_pass = 0;
  int ph     = 0;

  morse_keyer dut (
    .CLK       (clk),
    .RST       (rst_n),
    .CLK_2     (clk_2),
    .SYM       (sym),
    .VALID     (valid),
    .READY     (ready),
    .MORSE_OUT (morse_out),
    .BUSY      (busy),
    .ERR       (err),
    .BUZZER    (buzzer)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ph == P - 1) ph = 0;
    else ph = ph + 1;
    clk_2 = (ph >= P / 2);
  end

  // runs: mark/gap lengths in units, first run is a mark, one hex digit per run
  typedef struct packed {
    logic [5:0]  sym;
    logic [3:0]  n;
    logic [39:0] runs;
  } vec_t;

  vec_t vecs[7];
  int   exp_seq[11] = '{1, 1, 1, 1, 1, 9, 3, 1, 3, 1, 3};

  logic [3:0] trace[$];   // {buzzer, busy, ready, morse_out}
  logic       cap = 1'b0;
  int         runs[$];
  int         tail, inv_bad, buz_hi, busy_rises;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    if (cap) trace.push_back({buzzer, busy, ready, morse_out});
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < BOUND) begin
      step();
      k++;
    end
    chk("wait_ready", int'(ready), 1);
  endtask

  task automatic wait_morse(input logic v);
    int k = 0;
    while (morse_out !== v && k < BOUND) begin
      step();
      k++;
    end
    chk("wait_morse", int'(morse_out), int'(v));
  endtask

  // called at a negedge; the next posedge with READY=1 takes the symbol
  task automatic send(input logic [5:0] s, input bit drop);
    sym   = s;
    valid = 1'b1;
    wait_ready();
    step();
    if (drop) valid = 1'b0;
  endtask

  task automatic analyze();
    int   first1 = -1;
    int   last1  = -1;
    int   len    = 0;
    logic cur    = 1'b1;
    logic prev_busy = 1'b0;
    runs.delete();
    tail = 0; inv_bad = 0; buz_hi = 0; busy_rises = 0;
    foreach (trace[i]) begin
      if (trace[i][0]) begin
        if (first1 < 0) first1 = i;
        last1 = i;
      end
      if (trace[i][2] == trace[i][1]) inv_bad++;
      if (trace[i][3]) buz_hi++;
      if (trace[i][2] && !prev_busy) busy_rises++;
      prev_busy = trace[i][2];
    end
    if (first1 >= 0) begin
      for (int i = first1; i <= last1; i++) begin
        if (trace[i][0] == cur) len++;
        else begin
          runs.push_back(len);
          cur = trace[i][0];
          len = 1;
        end
      end
      runs.push_back(len);
      for (int i = last1 + 1; i < trace.size(); i++) begin
        if (trace[i][1]) break;
        tail++;
      end
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   ex;
    v = vecs[vi];
    trace.delete();
    cap = 1'b1;
    send(v.sym, 1'b1);
    chk($sformatf("v%0d_accept_busy", vi), int'(busy), 1);
    chk($sformatf("v%0d_accept_ready", vi), int'(ready), 0);
    wait_ready();
    cap = 1'b0;
    analyze();
    chk($sformatf("v%0d_nruns", vi), runs.size(), int'(v.n));
    for (int i = 0; i < int'(v.n); i++) begin
      ex = P * int'(v.runs[4 * (int'(v.n) - 1 - i) +: 4]);
      if (i < runs.size()) chk($sformatf("v%0d_run%0d", vi, i), runs[i], ex);
    end
    chk($sformatf("v%0d_lgap", vi), tail, 3 * P);
    chk($sformatf("v%0d_busy_vs_ready", vi), inv_bad, 0);
    chk($sformatf("v%0d_buzzer", vi), buz_hi, 0);
  endtask

  initial begin
    int hi;
    vecs[0] = '{sym: 6'd4,  n: 4'd1, runs: 40'h1};          // E
    vecs[1] = '{sym: 6'd0,  n: 4'd3, runs: 40'h113};        // A
    vecs[2] = '{sym: 6'd26, n: 4'd9, runs: 40'h313131313};  // 0
    vecs[3] = '{sym: 6'd19, n: 4'd1, runs: 40'h3};          // T
    vecs[4] = '{sym: 6'd10, n: 4'd5, runs: 40'h31113};      // K
    vecs[5] = '{sym: 6'd31, n: 4'd9, runs: 40'h111111111};  // 5
    vecs[6] = '{sym: 6'd11, n: 4'd7, runs: 40'h1131111};    // L

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_morse", int'(morse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", int'(ready), 1);

    // ticks while idle must not key anything
    hi = 0;
    repeat (3 * P) begin
      step();
      if (morse_out || busy) hi++;
    end
    chk("idle_ticks_ignored", hi, 0);

    foreach (vecs[i]) run_vec(i);

    // S, space, O with VALID held across all three handshakes
    trace.delete();
    cap = 1'b1;
    send(6'd18, 1'b0);
    send(6'd36, 1'b0);
    send(6'd14, 1'b1);
    wait_ready();
    cap = 1'b0;
    analyze();
    chk("seq_nruns", runs.size(), 11);
    foreach (exp_seq[i])
      if (i < runs.size()) chk($sformatf("seq_run%0d", i), runs[i], P * exp_seq[i]);
    chk("seq_lgap", tail, 3 * P);
    chk("seq_handshakes", busy_rises, 3);
    chk("seq_busy_vs_ready", inv_bad, 0);

    // invalid code: one-cycle ERR, nothing else moves
    sym   = 6'd40;
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_ready", int'(ready), 1);
    chk("err_busy", int'(busy), 0);
    chk("err_morse", int'(morse_out), 0);
    step();
    chk("err_clear", int'(err), 0);
    hi = 0;
    repeat (2 * P) begin
      step();
      if (morse_out || busy || err) hi++;
    end
    chk("err_no_activity", hi, 0);

    // reset in the middle of the second dash of O
    send(6'd14, 1'b1);
    wait_morse(1'b1);
    wait_morse(1'b0);
    wait_morse(1'b1);
    repeat (10) step();
    chk("pre_rst_morse", int'(morse_out), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_morse", int'(morse_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_buzzer", int'(buzzer), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_mid_rst", int'(ready), 1);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
